axi4_stream_pkt_hdr_insert: RTL and testbench

AXI4_STREAM_PKT_HDR_INSERT -- requirements
Module: axi4_stream_pkt_hdr_insert

---
 rtl/axi4_stream_pkt_hdr_insert_if.sv | 34 +++
 rtl/axi4_stream_pkt_hdr_insert.sv | 164 ++++++++++++++++
 tb/tb_axi4_stream_pkt_hdr_insert.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_stream_pkt_hdr_insert_if.sv
// ----------------------------------------------------------------------------
// axi4_stream_if
//   AXI4-Stream bundle shared by the header-insertion block and its neighbours.
//   master drives payload/sideband and tvalid, slave drives tready.
// Parameters
//   TDATA_WIDTH  data width in bits (multiple of 8); tkeep/tstrb are /8
//   TUSER_WIDTH, TDEST_WIDTH, TID_WIDTH  sideband widths
// ----------------------------------------------------------------------------
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TID_WIDTH   = 1
);
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tstrb;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic                     tlast;
  logic [TUSER_WIDTH-1:0]   tuser;
  logic [TDEST_WIDTH-1:0]   tdest;
  logic [TID_WIDTH-1:0]     tid;
  logic                     tvalid;
  logic                     tready;

  modport master (
    output tdata, tstrb, tkeep, tlast, tuser, tdest, tid, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tstrb, tkeep, tlast, tuser, tdest, tid, tvalid,
    output tready
  );
endinterface

// File: rtl/axi4_stream_pkt_hdr_insert.sv
// ----------------------------------------------------------------------------
// axi4_stream_pkt_hdr_insert
//   Prepends a one-beat size header to each packet of an AXI4-Stream and
//   checks the received byte count of the packet against that size.
//   Payload beats pass through with zero latency; the header beat is
//   presented while the input is held off (pkt_i.tready=0).
// Ports
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   hdr_en_i    insert header for the next packet (sampled at packet start)
//   pkt_size_i  byte size of the packet at the head of pkt_i
//   pkt_i       input stream (slave)
//   pkt_o       output stream (master)
//   len_err_o   one-cycle pulse after a checked packet with a size mismatch
//   pkt_cnt_o   packets completed at pkt_o, saturating
//   err_cnt_o   length errors seen, saturating
// ----------------------------------------------------------------------------
module axi4_stream_pkt_hdr_insert #(
  parameter int TDATA_WIDTH    = 32,
  parameter int TUSER_WIDTH    = 1,
  parameter int TDEST_WIDTH    = 1,
  parameter int TID_WIDTH      = 1,
  parameter int PKT_SIZE_WIDTH = 16,
  parameter bit HDR_USER_BIT   = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    hdr_en_i,
  input  logic [PKT_SIZE_WIDTH:0] pkt_size_i,
  axi4_stream_if.slave            pkt_i,
  axi4_stream_if.master           pkt_o,
  output logic                    len_err_o,
  output logic [31:0]             pkt_cnt_o,
  output logic [15:0]             err_cnt_o
);

  localparam int KEEP_WIDTH = TDATA_WIDTH / 8;
  localparam int CNT_WIDTH  = PKT_SIZE_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] BEAT_BYTES = CNT_WIDTH'(KEEP_WIDTH);

  generate
    if (PKT_SIZE_WIDTH > TDATA_WIDTH) begin : g_size_width_chk
      $error("PKT_SIZE_WIDTH must not exceed TDATA_WIDTH");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_HDR     = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_t;

  // Bytes carried by a last beat: position of the highest kept byte plus one.
  function automatic logic [CNT_WIDTH-1:0] last_beat_bytes(input logic [KEEP_WIDTH-1:0] keep);
    logic [CNT_WIDTH-1:0] n;
    n = {CNT_WIDTH{1'b0}};
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (keep[i]) begin
        n = CNT_WIDTH'(i + 1);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  state_t               state_r;
  logic                 chk_r;        // current packet carries a header and is length-checked
  logic [CNT_WIDTH-1:0] byte_cnt_r;
  logic [CNT_WIDTH-1:0] size_r;
  logic                 len_err_r;
  logic [31:0]          pkt_cnt_r;
  logic [15:0]          err_cnt_r;

  logic                 hdr_beat_s;
  logic                 in_hs_s;
  logic                 out_hs_s;
  logic [CNT_WIDTH-1:0] pkt_total_s;

  assign hdr_beat_s  = (state_r == ST_HDR) && hdr_en_i;
  assign in_hs_s     = pkt_i.tvalid && pkt_i.tready;
  assign out_hs_s    = pkt_o.tvalid && pkt_o.tready;
  // Modulo-2^CNT_WIDTH total so a wrapped counter is compared the same way.
  assign pkt_total_s = byte_cnt_r + last_beat_bytes(pkt_i.tkeep);

  // Output stream mux: header beat while in HDR with insertion enabled, else passthrough.
  always_comb begin
    pkt_o.tvalid = pkt_i.tvalid;
    pkt_o.tdest  = pkt_i.tdest;
    pkt_o.tid    = pkt_i.tid;
    if (hdr_beat_s) begin
      pkt_o.tdata  = TDATA_WIDTH'(pkt_size_i);
      pkt_o.tkeep  = {KEEP_WIDTH{1'b1}};
      pkt_o.tstrb  = {KEEP_WIDTH{1'b1}};
      pkt_o.tlast  = 1'b0;
      pkt_o.tuser  = HDR_USER_BIT ? TUSER_WIDTH'(1'b1) : pkt_i.tuser;
      pkt_i.tready = 1'b0;
    end else begin
      pkt_o.tdata  = pkt_i.tdata;
      pkt_o.tkeep  = pkt_i.tkeep;
      pkt_o.tstrb  = pkt_i.tstrb;
      pkt_o.tlast  = pkt_i.tlast;
      pkt_o.tuser  = pkt_i.tuser;
      pkt_i.tready = pkt_o.tready;
    end
  end

  // Packet FSM, byte counting, length check and saturating statistics.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= ST_HDR;
      chk_r      <= 1'b0;
      byte_cnt_r <= {CNT_WIDTH{1'b0}};
      size_r     <= {CNT_WIDTH{1'b0}};
      len_err_r  <= 1'b0;
      pkt_cnt_r  <= 32'd0;
      err_cnt_r  <= 16'd0;
    end else begin
      len_err_r <= 1'b0;
      case (state_r)
        ST_HDR: begin
          if (hdr_en_i) begin
            if (out_hs_s) begin
              size_r     <= pkt_size_i;
              byte_cnt_r <= {CNT_WIDTH{1'b0}};
              chk_r      <= 1'b1;
              state_r    <= ST_PAYLOAD;
            end
          end else if (in_hs_s && !pkt_i.tlast) begin
            // Unchecked packet: first beat already passed, rest follows in PAYLOAD.
            byte_cnt_r <= BEAT_BYTES;
            chk_r      <= 1'b0;
            state_r    <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (in_hs_s) begin
            if (pkt_i.tlast) begin
              state_r <= ST_HDR;
              if (chk_r && (pkt_total_s != size_r)) begin
                len_err_r <= 1'b1;
                if (err_cnt_r != 16'hFFFF) begin
                  err_cnt_r <= err_cnt_r + 16'd1;
                end
              end
            end else begin
              byte_cnt_r <= byte_cnt_r + BEAT_BYTES;
            end
          end
        end
        default: begin
          state_r <= ST_HDR;
        end
      endcase
      if (out_hs_s && pkt_o.tlast && (pkt_cnt_r != 32'hFFFF_FFFF)) begin
        pkt_cnt_r <= pkt_cnt_r + 32'd1;
      end
    end
  end

  assign len_err_o = len_err_r;
  assign pkt_cnt_o = pkt_cnt_r;
  assign err_cnt_o = err_cnt_r;

endmodule

// File: tb/tb_axi4_stream_pkt_hdr_insert.sv
// ----------------------------------------------------------------------------
// tb_axi4_stream_pkt_hdr_insert
//   Self-checking bench: each packet sent is expanded into the list of beats
//   that must appear on pkt_o (optional size header, then the payload as is),
//   together with whether a length error is due after its last beat. A
//   monitor matches every pkt_o handshake against that list, checks that
//   stalled beats hold steady, and checks len_err_o cycle by cycle.
// ----------------------------------------------------------------------------
module tb_axi4_stream_pkt_hdr_insert;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [1:0]  user;
    logic [3:0]  dest;
    logic [3:0]  id;
    bit          is_hdr;
    bit          err_after;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        hdr_en;
  logic [16:0] size_in;
  logic        len_err;
  logic [31:0] pkt_cnt;
  logic [15:0] err_cnt;

  int    n_checks   = 0;
  int    n_errors   = 0;
  int    err_pulses = 0;
  int    m_pkt      = 0;
  int    m_err      = 0;
  int    rdy_mode   = 0;   // 0: tready low, 1: tready high, 2: random
  bit    exp_err_next = 1'b0;
  beat_t exp_q[$];

  axi4_stream_if #(.TDATA_WIDTH(32), .TUSER_WIDTH(2), .TDEST_WIDTH(4), .TID_WIDTH(4)) pkt_in ();
  axi4_stream_if #(.TDATA_WIDTH(32), .TUSER_WIDTH(2), .TDEST_WIDTH(4), .TID_WIDTH(4)) pkt_out ();

  axi4_stream_pkt_hdr_insert #(
    .TDATA_WIDTH(32), .TUSER_WIDTH(2), .TDEST_WIDTH(4), .TID_WIDTH(4),
    .PKT_SIZE_WIDTH(16), .HDR_USER_BIT(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .hdr_en_i(hdr_en), .pkt_size_i(size_in),
    .pkt_i(pkt_in), .pkt_o(pkt_out),
    .len_err_o(len_err), .pkt_cnt_o(pkt_cnt), .err_cnt_o(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream ready generator.
  initial begin
    pkt_out.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       pkt_out.tready = 1'b0;
        1:       pkt_out.tready = 1'b1;
        default: pkt_out.tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: scoreboard match, stall stability, len_err timing.
  initial begin
    beat_t       e;
    bit          pv;
    logic [50:0] prev;
    logic [50:0] cur;
    pv = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {pkt_out.tdata, pkt_out.tkeep, pkt_out.tstrb, pkt_out.tlast,
             pkt_out.tuser, pkt_out.tdest, pkt_out.tid};
      if (rst) begin
        exp_q.delete();
        exp_err_next = 1'b0;
        pv = 1'b0;
      end else begin
        n_checks++;
        if (len_err !== exp_err_next) begin
          n_errors++;
          $display("FAIL len_err_pulse: got %b expected %b at %0t", len_err, exp_err_next, $time);
        end
        if (len_err === 1'b1) err_pulses++;
        exp_err_next = 1'b0;
        if (pv) begin
          n_checks++;
          if (pkt_out.tvalid !== 1'b1 || cur !== prev) begin
            n_errors++;
            $display("FAIL stall_hold: valid %b fields %h, required valid 1 fields %h at %0t",
                     pkt_out.tvalid, cur, prev, $time);
          end
        end
        if (pkt_out.tvalid === 1'b1 && pkt_out.tready === 1'b1) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_beat: got data %h with nothing expected at %0t", pkt_out.tdata, $time);
          end else begin
            e = exp_q.pop_front();
            if (pkt_out.tdata !== e.data || pkt_out.tkeep !== e.keep || pkt_out.tstrb !== e.keep ||
                pkt_out.tlast !== e.last || pkt_out.tdest !== e.dest || pkt_out.tid !== e.id ||
                (e.is_hdr ? (pkt_out.tuser[0] !== 1'b1) : (pkt_out.tuser !== e.user))) begin
              n_errors++;
              $display("FAIL beat_match(hdr=%0b): got d=%h k=%h s=%h l=%b u=%h dst=%h id=%h, required d=%h k=%h l=%b u=%h dst=%h id=%h at %0t",
                       e.is_hdr, pkt_out.tdata, pkt_out.tkeep, pkt_out.tstrb, pkt_out.tlast, pkt_out.tuser,
                       pkt_out.tdest, pkt_out.tid, e.data, e.keep, e.last, e.user, e.dest, e.id, $time);
            end
            exp_err_next = e.err_after;
          end
        end
        pv = (pkt_out.tvalid === 1'b1) && (pkt_out.tready !== 1'b1);
        prev = cur;
      end
    end
  end

  function automatic int keep_bytes(input logic [3:0] k);
    int b;
    b = 0;
    for (int i = 0; i < 4; i++) if (k[i]) b = i + 1;
    return b;
  endfunction

  // Send one packet; stop_after < nbeats abandons it after that many beats.
  task automatic send_pkt(input bit en, input logic [16:0] size, input int nbeats,
                          input logic [3:0] lkeep, input bit toggle, input int stop_after,
                          output int cyc);
    beat_t      pl[$];
    beat_t      b;
    logic [3:0] dst;
    logic [3:0] idv;
    int         sum;
    int         n;
    int         sent;
    bit         err;
    bit         hs;
    cyc = 0;
    dst = 4'($urandom);
    idv = 4'($urandom);
    sum = (nbeats - 1) * 4 + keep_bytes(lkeep);
    err = en && (17'(sum) != size);
    if (en) begin
      b.data = 32'(size); b.keep = 4'hF; b.last = 1'b0; b.user = 2'b01;
      b.dest = dst; b.id = idv; b.is_hdr = 1'b1; b.err_after = 1'b0;
      exp_q.push_back(b);
    end
    for (int i = 0; i < nbeats; i++) begin
      b.data = $urandom; b.keep = (i == nbeats - 1) ? lkeep : 4'hF;
      b.last = (i == nbeats - 1); b.user = 2'($urandom); b.dest = dst; b.id = idv;
      b.is_hdr = 1'b0; b.err_after = (i == nbeats - 1) && err;
      pl.push_back(b);
      exp_q.push_back(b);
    end
    if (stop_after >= nbeats) begin
      m_pkt++;
      if (err) m_err++;
    end
    hdr_en = en;
    size_in = size;
    sent = (stop_after < nbeats) ? stop_after : nbeats;
    for (int i = 0; i < sent; i++) begin
      pkt_in.tvalid = 1'b1;
      pkt_in.tdata = pl[i].data; pkt_in.tkeep = pl[i].keep; pkt_in.tstrb = pl[i].keep;
      pkt_in.tlast = pl[i].last; pkt_in.tuser = pl[i].user;
      pkt_in.tdest = pl[i].dest; pkt_in.tid = pl[i].id;
      n = 0;
      hs = 1'b0;
      while (!hs && n < 300) begin
        @(negedge clk);
        hs = (pkt_in.tready === 1'b1);
        @(posedge clk);
        #1;
        n++;
      end
      cyc += n;
      n_checks++;
      if (!hs) begin
        n_errors++;
        $display("FAIL handshake_timeout: beat %0d not accepted after %0d cycles, required acceptance", i, n);
      end
      if (toggle && i == 0 && nbeats > 1) hdr_en = !en;
    end
    if (sent < nbeats) pkt_in.tvalid = 1'b0;
  endtask

  task automatic idle(input int extra);
    int n;
    pkt_in.tvalid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d beats still outstanding, required 0", exp_q.size());
    end
    repeat (extra) @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string name, input int pulses_before, input int err_before);
    n_checks++;
    if (pkt_cnt !== 32'(m_pkt)) begin
      n_errors++;
      $display("FAIL %s pkt_cnt: got %0d required %0d", name, pkt_cnt, m_pkt);
    end
    n_checks++;
    if (err_cnt !== 16'(m_err)) begin
      n_errors++;
      $display("FAIL %s err_cnt: got %0d required %0d", name, err_cnt, m_err);
    end
    n_checks++;
    if (err_pulses - pulses_before !== m_err - err_before) begin
      n_errors++;
      $display("FAIL %s len_err_pulses: got %0d required %0d", name, err_pulses - pulses_before, m_err - err_before);
    end
  endtask

  task automatic test_reset();
    rdy_mode = 0;
    hdr_en = 1'b1;
    size_in = 17'h1234;
    @(negedge clk);
    n_checks++;
    if (pkt_cnt !== 32'd0 || err_cnt !== 16'd0 || len_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_regs: got cnt=%0d err=%0d len_err=%b required 0 0 0", pkt_cnt, err_cnt, len_err);
    end
    n_checks++;
    if (pkt_out.tdata !== 32'h0000_1234 || pkt_out.tkeep !== 4'hF || pkt_out.tlast !== 1'b0 ||
        pkt_out.tvalid !== 1'b0 || pkt_in.tready !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_hdr_beat: got d=%h k=%h l=%b v=%b rdy=%b required d=00001234 k=f l=0 v=0 rdy=0",
               pkt_out.tdata, pkt_out.tkeep, pkt_out.tlast, pkt_out.tvalid, pkt_in.tready);
    end
    #1;
    hdr_en = 1'b0;
    pkt_in.tdata = 32'hCAFE_0042;
    #1;
    n_checks++;
    if (pkt_out.tdata !== 32'hCAFE_0042) begin
      n_errors++;
      $display("FAIL reset_passthrough: got %h required cafe0042", pkt_out.tdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int cyc;
    int p0;
    int e0;
    rdy_mode = 1; idle(2);
    p0 = err_pulses; e0 = m_err;
    send_pkt(1'b1, 17'd10, 3, 4'h3, 1'b0, 99, cyc);
    idle(3);
    n_checks++;
    if (cyc !== 4) begin
      n_errors++;
      $display("FAIL basic_cycles: got %0d required 4", cyc);
    end
    check_counters("basic", p0, e0);
  endtask

  task automatic test_len_err();
    int cyc;
    int p0;
    int e0;
    rdy_mode = 1; idle(2);
    p0 = err_pulses; e0 = m_err;
    send_pkt(1'b1, 17'd12, 3, 4'h3, 1'b0, 99, cyc);
    idle(3);
    check_counters("len_err", p0, e0);
  endtask

  task automatic test_passthrough();
    int cyc;
    int tot;
    int p0;
    int e0;
    rdy_mode = 1; idle(2);
    p0 = err_pulses; e0 = m_err;
    send_pkt(1'b0, 17'($urandom), 4, 4'hF, 1'b0, 99, cyc); tot = cyc;
    send_pkt(1'b0, 17'($urandom), 4, 4'h7, 1'b0, 99, cyc); tot += cyc;
    idle(3);
    n_checks++;
    if (tot !== 8) begin
      n_errors++;
      $display("FAIL passthrough_cycles: got %0d required 8", tot);
    end
    check_counters("passthrough", p0, e0);
  endtask

  task automatic test_back_to_back();
    int cyc;
    int tot;
    int p0;
    int e0;
    logic [3:0] lk;
    rdy_mode = 1; idle(2);
    p0 = err_pulses; e0 = m_err; tot = 0;
    for (int i = 0; i < 3; i++) begin
      lk = 4'($urandom_range(1, 15));
      send_pkt(1'b1, 17'(8 + keep_bytes(lk)), 3, lk, 1'b0, 99, cyc);
      tot += cyc;
    end
    idle(3);
    n_checks++;
    if (tot !== 12) begin
      n_errors++;
      $display("FAIL back_to_back_cycles: got %0d required 12", tot);
    end
    check_counters("back_to_back", p0, e0);
  endtask

  task automatic test_toggle();
    int cyc;
    int p0;
    int e0;
    rdy_mode = 1; idle(2);
    p0 = err_pulses; e0 = m_err;
    send_pkt(1'b1, 17'd1, 1, 4'h1, 1'b0, 99, cyc);
    n_checks++;
    if (cyc !== 2) begin
      n_errors++;
      $display("FAIL toggle_single_cycles: got %0d required 2", cyc);
    end
    send_pkt(1'b1, 17'd12, 3, 4'hF, 1'b1, 99, cyc);
    n_checks++;
    if (cyc !== 4) begin
      n_errors++;
      $display("FAIL toggle_off_cycles: got %0d required 4", cyc);
    end
    send_pkt(1'b0, 17'd3, 3, 4'hF, 1'b1, 99, cyc);
    n_checks++;
    if (cyc !== 3) begin
      n_errors++;
      $display("FAIL toggle_on_cycles: got %0d required 3", cyc);
    end
    idle(3);
    check_counters("toggle", p0, e0);
  endtask

  task automatic test_random_stall();
    int cyc;
    int nb;
    int p0;
    int e0;
    bit en;
    logic [3:0] lk;
    logic [16:0] sz;
    rdy_mode = 2; idle(2);
    p0 = err_pulses; e0 = m_err;
    for (int i = 0; i < 30; i++) begin
      en = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 5);
      lk = 4'($urandom);
      sz = ($urandom_range(0, 1) == 1) ? 17'((nb - 1) * 4 + keep_bytes(lk)) : 17'($urandom);
      send_pkt(en, sz, nb, lk, 1'($urandom_range(0, 1)), 99, cyc);
    end
    idle(3);
    check_counters("random_stall", p0, e0);
  endtask

  task automatic test_reset_mid();
    int cyc;
    rdy_mode = 1; idle(2);
    send_pkt(1'b1, 17'd20, 5, 4'hF, 1'b0, 2, cyc);
    rst = 1'b1;
    m_pkt = 0;
    m_err = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (pkt_cnt !== 32'd0 || err_cnt !== 16'd0 || len_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_regs: got cnt=%0d err=%0d len_err=%b required 0 0 0", pkt_cnt, err_cnt, len_err);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_pkt(1'b1, 17'd4, 1, 4'hF, 1'b0, 99, cyc);
    idle(3);
    n_checks++;
    if (cyc !== 2) begin
      n_errors++;
      $display("FAIL reset_mid_cycles: got %0d required 2", cyc);
    end
    check_counters("reset_mid", err_pulses, 0);
  endtask

  initial begin
    rst = 1'b1;
    hdr_en = 1'b0;
    size_in = 17'd0;
    pkt_in.tvalid = 1'b0; pkt_in.tdata = 32'd0; pkt_in.tkeep = 4'd0; pkt_in.tstrb = 4'd0;
    pkt_in.tlast = 1'b0; pkt_in.tuser = 2'd0; pkt_in.tdest = 4'd0; pkt_in.tid = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_basic();
    test_len_err();
    test_passthrough();
    test_back_to_back();
    test_toggle();
    test_random_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
